// File: rtl/dma_write_scheduler_pkg.sv
// Shared definitions for the DMA write scheduler.
// Holds the scheduler state encoding, the write-engine address/length widths
// (shared with the write control block), the chunk counter width and the default
// completion timeout.
package dma_write_scheduler_pkg;

  localparam int unsigned DmaAddrWidth         = 32;
  localparam int unsigned DmaLenWidth          = 26;
  localparam int unsigned ChunkCntWidth        = 16;
  localparam int unsigned DefaultTimeoutCycles = 1048576;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIdle,
    StIssue,
    StWaitIrq,
    StFinish
  } state_e;

endpackage

// File: rtl/dma_write_scheduler_if.sv
// Job-control and write-engine signal bundle for the DMA write scheduler.
//   master : the scheduler (drives engine commands and status)
//   slave  : the layer controller / write engine side
// Job control : start, abort, cfg_base_addr, cfg_chunk_bytes, cfg_stride, cfg_chunk_num
// Engine      : dma_da_config, dma_length_config, dma_write_valid, dma_write_idle,
//               dma_write_irq
// Status      : busy, done, error, chunks_done
interface dma_write_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = dma_write_scheduler_pkg::DmaAddrWidth,
  parameter int unsigned LEN_WIDTH  = dma_write_scheduler_pkg::DmaLenWidth,
  parameter int unsigned CNT_WIDTH  = dma_write_scheduler_pkg::ChunkCntWidth
);

  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] cfg_base_addr;
  logic [LEN_WIDTH-1:0]  cfg_chunk_bytes;
  logic [ADDR_WIDTH-1:0] cfg_stride;
  logic [CNT_WIDTH-1:0]  cfg_chunk_num;

  logic [ADDR_WIDTH-1:0] dma_da_config;
  logic [LEN_WIDTH-1:0]  dma_length_config;
  logic                  dma_write_valid;
  logic                  dma_write_idle;
  logic                  dma_write_irq;

  logic                  busy;
  logic                  done;
  logic                  error;
  logic [CNT_WIDTH-1:0]  chunks_done;

  modport master (
    input  start, abort, cfg_base_addr, cfg_chunk_bytes, cfg_stride, cfg_chunk_num,
    input  dma_write_idle, dma_write_irq,
    output dma_da_config, dma_length_config, dma_write_valid,
    output busy, done, error, chunks_done
  );

  modport slave (
    output start, abort, cfg_base_addr, cfg_chunk_bytes, cfg_stride, cfg_chunk_num,
    output dma_write_idle, dma_write_irq,
    input  dma_da_config, dma_length_config, dma_write_valid,
    input  busy, done, error, chunks_done
  );

endinterface

// File: rtl/dma_write_scheduler_timeout.sv
// Per-chunk completion watchdog.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart the count from zero (has priority over enable_i)
//   enable_i      : count this cycle
//   expired_o     : this is the TIMEOUT_CYCLES-th counted cycle; never set when
//                   TIMEOUT_CYCLES is 0
module dma_timeout_counter
  import dma_write_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LastVal = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CntW-1:0] Last = CntW'(LastVal);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != Last)) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count holds Last during the final counted cycle, so the owner acts on the same edge.
  assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (count_q == Last);

endmodule

// File: rtl/dma_write_scheduler.sv
// DMA write scheduler: splits one output-store job into single-chunk write commands.
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus (master)  : job start/abort and config in; engine address/length/valid out,
//                   engine idle/irq in; busy, done, sticky error and chunk progress out
// All outputs are registered. The command address/length registers double as the
// engine config outputs and only change at job start or between chunks.
module dma_write_scheduler
  import dma_write_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DmaAddrWidth,
  parameter int unsigned LEN_WIDTH      = DmaLenWidth,
  parameter int unsigned CNT_WIDTH      = ChunkCntWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input logic                   aclk,
  input logic                   aresetn,
  dma_write_scheduler_if.master bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] da_q, da_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  chunks_q, chunks_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic tmr_clear, tmr_enable, tmr_expired;

  assign tmr_clear  = (state_q == StIssue);
  assign tmr_enable = (state_q == StWaitIrq) && !bus.dma_write_irq && !bus.abort;

  dma_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (aclk),
    .rst_ni   (aresetn),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    da_d     = da_q;
    stride_d = stride_q;
    len_d    = len_q;
    num_d    = num_q;
    chunks_d = chunks_q;
    busy_d   = busy_q;
    error_d  = error_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    if ((state_q != StIdle) && bus.abort) begin
      // Abort beats everything, including a coincident irq; progress stays frozen.
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            da_d     = bus.cfg_base_addr;
            stride_d = bus.cfg_stride;
            len_d    = bus.cfg_chunk_bytes;
            num_d    = bus.cfg_chunk_num;
            chunks_d = '0;
            error_d  = 1'b0;
            busy_d   = 1'b1;
            if ((bus.cfg_chunk_num == '0) || (bus.cfg_chunk_bytes == '0)) begin
              state_d = StFinish;
            end else begin
              state_d = StWaitIdle;
            end
          end
        end
        StWaitIdle: begin
          if (bus.dma_write_idle) begin
            state_d = StIssue;
            valid_d = 1'b1;
          end
        end
        StIssue: begin
          // An irq here predates this command and is dropped.
          state_d = StWaitIrq;
        end
        StWaitIrq: begin
          if (bus.dma_write_irq) begin
            chunks_d = chunks_q + CNT_WIDTH'(1);
            if (chunks_d == num_q) begin
              state_d = StFinish;
            end else begin
              da_d    = da_q + stride_q;
              state_d = StWaitIdle;
            end
          end else if (tmr_expired) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
        StFinish: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      da_q     <= '0;
      stride_q <= '0;
      len_q    <= '0;
      num_q    <= '0;
      chunks_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      da_q     <= da_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      num_q    <= num_d;
      chunks_q <= chunks_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign bus.dma_da_config     = da_q;
  assign bus.dma_length_config = len_q;
  assign bus.dma_write_valid   = valid_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.error             = error_q;
  assign bus.chunks_done       = chunks_q;

endmodule

// File: tb/tb_dma_write_scheduler.sv
// Self-checking bench for dma_write_scheduler: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// job-level reference model.
module tb_dma_write_scheduler;

  localparam int TMO = 64;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  dma_write_scheduler_if #(.ADDR_WIDTH(32), .LEN_WIDTH(26), .CNT_WIDTH(16)) bus ();

  dma_write_scheduler #(
    .ADDR_WIDTH    (32),
    .LEN_WIDTH     (26),
    .CNT_WIDTH     (16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  initial forever #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: expected outputs after each edge.
  logic [31:0] m_da;
  logic [25:0] m_len;
  logic [15:0] m_chunks;
  bit          m_busy, m_done, m_error, m_valid;
  // Job bookkeeping.
  logic [31:0] j_base, j_stride;
  logic [15:0] j_num;
  int          j_issued, j_age;
  bit          j_want, j_fresh, j_wait, j_finish;

  // Event log for directed checks.
  logic [31:0] vq[$];
  logic [25:0] lq[$];
  int n_valid, n_done, n_busycyc, done_cyc, err_cyc, first_valid_cyc, last_valid_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    m_valid = 1'b0;
    m_done  = 1'b0;
    if (!aresetn) begin
      m_da = '0; m_len = '0; m_chunks = '0;
      m_busy = 0; m_error = 0;
      j_want = 0; j_fresh = 0; j_wait = 0; j_finish = 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        j_base   = bus.cfg_base_addr;
        j_stride = bus.cfg_stride;
        j_num    = bus.cfg_chunk_num;
        m_len    = bus.cfg_chunk_bytes;
        m_da     = j_base;
        m_chunks = '0;
        m_error  = 0;
        m_busy   = 1;
        j_issued = 0;
        if (j_num == 0 || m_len == 0) j_finish = 1;
        else j_want = 1;
      end
    end else if (bus.abort) begin
      m_busy = 0;
      j_want = 0; j_fresh = 0; j_wait = 0; j_finish = 0;
    end else if (j_finish) begin
      m_done = 1; m_busy = 0; j_finish = 0;
    end else if (j_want) begin
      if (bus.dma_write_idle) begin
        m_valid = 1; j_want = 0; j_fresh = 1; j_issued++;
      end
    end else if (j_fresh) begin
      j_fresh = 0; j_wait = 1; j_age = 0;
    end else if (j_wait) begin
      if (bus.dma_write_irq) begin
        m_chunks++;
        j_wait = 0;
        if (m_chunks == j_num) j_finish = 1;
        else begin
          m_da   = j_base + 32'(j_issued) * j_stride;
          j_want = 1;
        end
      end else begin
        j_age++;
        if (j_age == TMO) begin
          m_error = 1; m_busy = 0; j_wait = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("busy",        64'(bus.busy),              64'(m_busy));
    chk("done",        64'(bus.done),              64'(m_done));
    chk("error",       64'(bus.error),             64'(m_error));
    chk("valid",       64'(bus.dma_write_valid),   64'(m_valid));
    chk("chunks_done", 64'(bus.chunks_done),       64'(m_chunks));
    chk("da",          64'(bus.dma_da_config),     64'(m_da));
    chk("len",         64'(bus.dma_length_config), 64'(m_len));
    if (bus.dma_write_valid === 1'b1) begin
      vq.push_back(bus.dma_da_config);
      lq.push_back(bus.dma_length_config);
      n_valid++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
    end
    if (bus.done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (bus.busy === 1'b1) n_busycyc++;
    if (bus.error === 1'b1 && err_cyc < 0) err_cyc = cyc;
  endtask

  task automatic cycle();
    @(posedge aclk);
    model_step();
    @(negedge aclk);
    cyc++;
    compare_all();
  endtask

  task automatic clear_log();
    vq.delete(); lq.delete();
    n_valid = 0; n_done = 0; n_busycyc = 0;
    done_cyc = -1; err_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1;
  endtask

  task automatic start_job(input logic [31:0] base, input logic [25:0] bytes,
                           input logic [31:0] stride, input logic [15:0] num);
    bus.cfg_base_addr   = base;
    bus.cfg_chunk_bytes = bytes;
    bus.cfg_stride      = stride;
    bus.cfg_chunk_num   = num;
    bus.start           = 1'b1;
    cycle();
    bus.start           = 1'b0;
  endtask

  // Runs until busy drops. irq answers each valid irq_delay cycles later (<=0: never);
  // the answer to valid number abort_at also carries abort.
  task automatic drive_job(input int irq_delay, input int abort_at, input int max_cyc);
    int cd;
    bit fin;
    cd  = -1;
    fin = 0;
    for (int k = 0; k < max_cyc; k++) begin
      bus.dma_write_irq = (cd == 0);
      bus.abort         = (cd == 0) && (n_valid == abort_at);
      if (cd >= 0) cd--;
      cycle();
      if (bus.dma_write_valid === 1'b1 && irq_delay > 0) cd = irq_delay - 1;
      if (bus.busy !== 1'b1) begin
        fin = 1;
        break;
      end
    end
    bus.dma_write_irq = 1'b0;
    bus.abort         = 1'b0;
    chk("job_ends_in_budget", 64'(fin), 64'(1));
  endtask

  logic [31:0] exp_da[3];
  int s_cyc, rise_cyc;

  initial begin
    bus.start = 0; bus.abort = 0; bus.dma_write_idle = 0; bus.dma_write_irq = 0;
    bus.cfg_base_addr = '0; bus.cfg_chunk_bytes = '0; bus.cfg_stride = '0;
    bus.cfg_chunk_num = '0;
    clear_log();
    cycle();
    cycle();
    chk("rst_busy",   64'(bus.busy),              64'(0));
    chk("rst_da",     64'(bus.dma_da_config),     64'(0));
    chk("rst_len",    64'(bus.dma_length_config), 64'(0));
    chk("rst_chunks", 64'(bus.chunks_done),       64'(0));
    aresetn = 1'b1;
    cycle();

    // Three chunks, irq 20 cycles after each command.
    bus.dma_write_idle = 1'b1;
    clear_log();
    exp_da = '{32'h1000_0000, 32'h1000_0800, 32'h1000_1000};
    start_job(32'h1000_0000, 26'h400, 32'h800, 16'd3);
    drive_job(20, 0, 400);
    chk("s1_nvalid", 64'(vq.size()), 64'(3));
    for (int i = 0; i < vq.size() && i < 3; i++) begin
      chk("s1_da",  64'(vq[i]), 64'(exp_da[i]));
      chk("s1_len", 64'(lq[i]), 64'(26'h400));
    end
    chk("s1_chunks", 64'(bus.chunks_done), 64'(3));
    chk("s1_ndone",  64'(n_done),          64'(1));
    chk("s1_error",  64'(bus.error),       64'(0));
    cycle();

    // Zero-chunk job: done on the second cycle, one busy cycle, no command.
    clear_log();
    start_job(32'h2000_0000, 26'h10, 32'h10, 16'd0);
    s_cyc = cyc;
    drive_job(5, 0, 10);
    chk("s2_done_cyc", 64'(done_cyc - s_cyc), 64'(1));
    chk("s2_busycyc",  64'(n_busycyc),        64'(1));
    chk("s2_nvalid",   64'(n_valid),          64'(0));
    cycle();

    // Address wrap.
    clear_log();
    start_job(32'hFFFF_FC00, 26'h100, 32'h400, 16'd2);
    drive_job(3, 0, 100);
    chk("s3_nvalid", 64'(vq.size()), 64'(2));
    if (vq.size() == 2) chk("s3_wrap_da", 64'(vq[1]), 64'(0));
    chk("s3_ndone", 64'(n_done), 64'(1));
    cycle();

    // Timeout: irq never comes.
    clear_log();
    start_job(32'h3000_0000, 26'h80, 32'h80, 16'd2);
    drive_job(0, 0, 200);
    chk("s4_err_lat", 64'(err_cyc - first_valid_cyc), 64'(TMO + 1));
    chk("s4_error",   64'(bus.error),                 64'(1));
    chk("s4_busy",    64'(bus.busy),                  64'(0));
    chk("s4_ndone",   64'(n_done),                    64'(0));
    cycle();
    start_job(32'h0, 26'h0, 32'h0, 16'd1);
    chk("s4_err_cleared", 64'(bus.error), 64'(0));
    drive_job(3, 0, 20);
    cycle();

    // Engine not idle for 10 cycles after start.
    clear_log();
    bus.dma_write_idle = 1'b0;
    start_job(32'h4000_0000, 26'h40, 32'h40, 16'd1);
    for (int k = 0; k < 10; k++) cycle();
    chk("s5_no_valid", 64'(n_valid), 64'(0));
    bus.dma_write_idle = 1'b1;
    rise_cyc = cyc + 1;
    drive_job(4, 0, 50);
    chk("s5_valid_cyc", 64'(first_valid_cyc), 64'(rise_cyc));
    chk("s5_ndone",     64'(n_done),          64'(1));
    cycle();

    // Abort coincident with the irq of chunk 2 of 4, then a fresh job.
    clear_log();
    start_job(32'h5000_0000, 26'h20, 32'h100, 16'd4);
    drive_job(5, 2, 100);
    chk("s6_chunks", 64'(bus.chunks_done), 64'(1));
    chk("s6_ndone",  64'(n_done),          64'(0));
    chk("s6_busy",   64'(bus.busy),        64'(0));
    cycle();
    clear_log();
    start_job(32'h6000_0000, 26'h30, 32'h0, 16'd1);
    drive_job(5, 0, 50);
    chk("s6_fresh_da",     64'(last_valid_cyc >= 0 ? vq[0] : 32'hx), 64'(32'h6000_0000));
    chk("s6_fresh_chunks", 64'(bus.chunks_done), 64'(1));
    chk("s6_fresh_ndone",  64'(n_done),          64'(1));
    cycle();

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int k = 0; k < 3000; k++) begin
      bus.dma_write_idle = ($urandom_range(0, 3) != 0);
      bus.dma_write_irq  = ($urandom_range(0, 7) == 0);
      bus.abort          = ($urandom_range(0, 63) == 0);
      bus.start          = ($urandom_range(0, 15) == 0);
      bus.cfg_base_addr  = $urandom;
      bus.cfg_stride     = $urandom;
      bus.cfg_chunk_num  = 16'($urandom_range(0, 4));
      bus.cfg_chunk_bytes = ($urandom_range(0, 7) == 0) ? 26'h0 : 26'($urandom);
      cycle();
    end
    bus.start = 0; bus.abort = 0; bus.dma_write_irq = 0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
